// File: rtl/maxnet_controller.sv
// Sequencer for a MAXNET winner-take-all datapath: loads x and weights, then
// alternates PU settle time with a-register updates until one winner remains.
module maxnet_controller #(
    parameter int PU_LATENCY = 2,
    parameter int MAX_ITER   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       is_finished,
    output logic       init_x,
    output logic       init_w,
    output logic       load_sel,
    output logic       load_a,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [4:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_CALC,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(PU_LATENCY - 1);
    localparam logic [4:0] ITER_MAX  = 5'(MAX_ITER);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_wait;
    logic [4:0] r_iter;
    logic       r_timeout;
    logic       w_accept;
    logic       w_abort;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_abort  = (r_state != S_IDLE) && abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_INIT;
            S_INIT:   w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_CALC;
            S_CALC:   if (r_wait == WAIT_LAST) w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_CHECK;
            S_CHECK: begin
                if (is_finished || (r_iter == ITER_MAX)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        // Abort overrides every other transition.
        if (w_abort) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= '0;
            r_iter    <= '0;
            r_timeout <= 1'b0;
        end else begin
            // Wait counter restarts on every entry into CALC.
            if ((r_state == S_CALC) && (w_state_next == S_CALC)) begin
                r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= '0;
            end

            if (w_accept) begin
                r_iter <= '0;
            end else if ((r_state == S_UPDATE) && !w_abort && (r_iter != ITER_MAX)) begin
                r_iter <= r_iter + 5'd1;
            end

            if (w_accept || w_abort) begin
                r_timeout <= 1'b0;
            end else if ((r_state == S_CHECK) && (w_state_next == S_DONE)) begin
                r_timeout <= !is_finished;
            end
        end
    end

    assign init_x     = (r_state == S_INIT);
    assign init_w     = (r_state == S_INIT);
    assign load_sel   = (r_state == S_LOAD);
    assign load_a     = (r_state == S_LOAD) || (r_state == S_UPDATE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign timeout    = r_timeout;
    assign iter_count = r_iter;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: default instance plus a MAX_ITER=4
// instance; expected run results are queued at start and compared at done.
module tb_maxnet_controller;

    typedef struct {
        int          done_cyc;
        logic [4:0]  iter;
        logic        tmo;
        logic [31:0] la_mask;
        logic [31:0] init_mask;
        logic [31:0] sel_mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    logic start, abort, fin;

    logic start_a, abort_a, fin_a, start_b, abort_b, fin_b;
    logic init_x_a, init_w_a, load_sel_a, load_a_a, busy_a, done_a, timeout_a;
    logic init_x_b, init_w_b, load_sel_b, load_a_b, busy_b, done_b, timeout_b;
    logic [4:0] iter_a, iter_b;

    logic w_init_x, w_init_w, w_load_sel, w_load_a, w_busy, w_done, w_timeout;
    logic [4:0] w_iter;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign start_a = sel ? 1'b0 : start;
    assign abort_a = sel ? 1'b0 : abort;
    assign fin_a   = sel ? 1'b0 : fin;
    assign start_b = sel ? start : 1'b0;
    assign abort_b = sel ? abort : 1'b0;
    assign fin_b   = sel ? fin : 1'b0;

    assign w_init_x   = sel ? init_x_b   : init_x_a;
    assign w_init_w   = sel ? init_w_b   : init_w_a;
    assign w_load_sel = sel ? load_sel_b : load_sel_a;
    assign w_load_a   = sel ? load_a_b   : load_a_a;
    assign w_busy     = sel ? busy_b     : busy_a;
    assign w_done     = sel ? done_b     : done_a;
    assign w_timeout  = sel ? timeout_b  : timeout_a;
    assign w_iter     = sel ? iter_b     : iter_a;

    maxnet_controller dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .is_finished(fin_a), .init_x(init_x_a), .init_w(init_w_a),
        .load_sel(load_sel_a), .load_a(load_a_a), .busy(busy_a),
        .done(done_a), .timeout(timeout_a), .iter_count(iter_a)
    );

    maxnet_controller #(.PU_LATENCY(2), .MAX_ITER(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .is_finished(fin_b), .init_x(init_x_b), .init_w(init_w_b),
        .load_sel(load_sel_b), .load_a(load_a_b), .busy(busy_b),
        .done(done_b), .timeout(timeout_b), .iter_count(iter_b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input logic [4:0] it, input logic tm,
                                input logic [31:0] la);
        exp_t e;
        e.done_cyc  = d;
        e.iter      = it;
        e.tmo       = tm;
        e.la_mask   = la;
        e.init_mask = 32'h2;
        e.sel_mask  = 32'h4;
        return e;
    endfunction

    // Start a run at the next edge, drive is_finished in cycles fin_on..fin_off,
    // then compare the observed run against the queued expectation.
    task automatic run(input logic use_b, input int fin_on, input int fin_off,
                       input exp_t e, input string tag);
        exp_t got;
        int c;
        bit seen;
        int dc;
        logic [4:0] it;
        logic tm;
        logic [31:0] la, im, sm;
        sel = use_b;
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1; seen = 0; dc = 0; it = '0; tm = 1'b0;
        la = '0; im = '0; sm = '0;
        while (!seen && c <= 40) begin
            if (c < 32) begin
                la[c] = w_load_a;
                im[c] = w_init_x & w_init_w;
                sm[c] = w_load_sel;
            end
            if (w_done) begin
                seen = 1; dc = c; it = w_iter; tm = w_timeout;
                check({tag, "_busy_at_done"}, 32'(w_busy), 32'd1);
            end else begin
                fin = (c >= fin_on) && (c <= fin_off);
                tick();
                c++;
            end
        end
        fin = 1'b0;
        got = sb_q.pop_front();
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_done_cycle"}, 32'(dc), 32'(got.done_cyc));
            check({tag, "_iter"}, 32'(it), 32'(got.iter));
            check({tag, "_timeout"}, 32'(tm), 32'(got.tmo));
            check({tag, "_load_a_cycles"}, la, got.la_mask);
            check({tag, "_init_cycles"}, im, got.init_mask);
            check({tag, "_load_sel_cycles"}, sm, got.sel_mask);
            tick();
            check({tag, "_idle_after"}, {30'd0, w_busy, w_done}, 32'd0);
            check({tag, "_held"}, {26'd0, w_timeout, w_iter}, {26'd0, got.tmo, got.iter});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int c;
        rst_n = 1'b1; sel = 1'b0; start = 1'b0; abort = 1'b0; fin = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_a_outputs",
              {23'd0, init_x_a, init_w_a, load_sel_a, load_a_a, busy_a, done_a, timeout_a, iter_a}, 32'd0);
        check("reset_b_outputs",
              {23'd0, init_x_b, init_w_b, load_sel_b, load_a_b, busy_b, done_b, timeout_b, iter_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run(1'b0, 3, 100, mk(7, 5'd1, 1'b0, 32'h24), "single_iter");
        run(1'b0, 14, 14, mk(15, 5'd3, 1'b0, 32'h2224), "three_iter");
        run(1'b1, 100, 100, mk(19, 5'd4, 1'b1, 32'h22224), "timeout_max4");
        run(1'b1, 18, 18, mk(19, 5'd4, 1'b0, 32'h22224), "tie_at_limit");

        // Abort at c8 with start held high; restart lands at c9 edge.
        sel = 1'b0; fin = 1'b0; start = 1'b1; seen = 0;
        tick();
        for (int k = 1; k < 8; k++) begin
            seen = seen | w_done;
            tick();
        end
        check("abort_busy_c8", 32'(w_busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seen = seen | w_done;
        check("abort_idle_c9", {29'd0, w_busy, w_done, w_init_x}, 32'd0);
        check("abort_iter_c9", 32'(w_iter), 32'd1);
        tick();
        check("abort_restart_init_c10", {30'd0, w_init_x, w_busy}, 32'd3);
        check("abort_no_done", 32'(seen), 32'd0);
        start = 1'b0; fin = 1'b1;
        sb_q.push_back(mk(0, 5'd1, 1'b0, 32'h0));
        c = 0;
        while (!w_done && c < 30) begin
            tick();
            c++;
        end
        fin = 1'b0;
        check("abort_rerun_done_seen", 32'(w_done), 32'd1);
        check("abort_rerun_result", {26'd0, w_timeout, w_iter},
              {26'd0, sb_q[0].tmo, sb_q[0].iter});
        void'(sb_q.pop_front());
        tick();

        // Reset pulse between edges while in CALC.
        sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_calc_busy", {30'd0, w_busy, w_load_a}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {23'd0, w_init_x, w_init_w, w_load_sel, w_load_a, w_busy, w_done, w_timeout, w_iter}, 32'd0);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | w_done | w_busy;
        end
        check("post_reset_quiet_20", 32'(seen), 32'd0);

        // Start sampled on the very first edge after reset release.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        run(1'b0, 3, 100, mk(7, 5'd1, 1'b0, 32'h24), "first_edge_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 Parameter PU_LATENCY, default 2: the number of clk cycles the PUs need after the a-registers change before their outputs are valid; legal range 1..15.
REQ-002 Parameter MAX_ITER, default 20: the iteration limit before a forced stop; legal range 1..31.
REQ-003 clk  input  1: the single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: run request, sampled only in IDLE.
REQ-006 abort  input  1: synchronous abort, honoured in any non-IDLE state.
REQ-007 is_finished  input  1: from the datapath check logic; high when at most one a-value is nonzero.
REQ-008 init_x  output  1: loads the input x registers in the datapath.
REQ-009 init_w  output  1: loads the weight registers in the datapath.
REQ-010 load_sel  output  1: a-mux select; 1 selects initial x, 0 selects PU outputs.
REQ-011 load_a  output  1: write enable for the a1..a4 registers.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 done  output  1: one-cycle pulse when a run completes.
REQ-014 timeout  output  1: high when the last run stopped on MAX_ITER without reaching is_finished.
REQ-015 iter_count  output  5: number of UPDATE cycles in the current or last run.

Function
REQ-016 All outputs SHALL be Moore, decoded from the registered state and counters only; no input-to-output combinational path.
REQ-017 The states SHALL be IDLE, INIT, LOAD, CALC, UPDATE, CHECK and DONE.
REQ-018 IDLE: all strobes low; start=1 at an edge -> INIT, clearing iter_count and timeout on the same edge.
REQ-019 INIT, 1 cycle: init_x=1, init_w=1 -> LOAD.
REQ-020 LOAD, 1 cycle: load_sel=1, load_a=1 -> CALC.
REQ-021 CALC, exactly PU_LATENCY cycles, counted by an internal wait counter: load_a=0, load_sel=0 -> UPDATE.
REQ-022 UPDATE, 1 cycle: load_a=1, load_sel=0; iter_count increments by 1 -> CHECK.
REQ-023 CHECK, 1 cycle: is_finished is sampled here only.
  - If is_finished=1 -> DONE, timeout=0.
  - Else if iter_count==MAX_ITER -> DONE, timeout=1.
  - Else -> CALC.
REQ-024 is_finished=1 and iter_count==MAX_ITER in the same CHECK SHALL resolve as finished, with timeout=0.
REQ-025 DONE, 1 cycle: done=1 -> IDLE; iter_count and timeout are held until the next accepted start.
REQ-026 start while busy=1 SHALL be ignored, with no queuing; start held high through DONE is accepted again in IDLE.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge.
  - done is not pulsed.
  - iter_count is held; timeout=0.
  - abort has priority over every other transition.
REQ-028 iter_count SHALL never exceed MAX_ITER and SHALL never wrap.
REQ-029 Latency from the start edge to the done cycle SHALL be 3 + n*(PU_LATENCY+2) cycles, where n is the number of iterations.

Reset
REQ-030 rst_n=0 SHALL force IDLE immediately, independent of clk.
  - All outputs go to 0, iter_count=0.
  - The internal counters clear.
REQ-031 Reset asserted mid-run SHALL abandon the run with no done pulse; after release the block waits for a new start.
REQ-032 The first clk edge after rst_n rises SHALL be a valid IDLE sample.

Verification
REQ-033 Single iteration, defaults:
  - Stimulus: start pulse at edge 0; is_finished=1 from cycle 3.
  - Response: INIT at c1, LOAD at c2, CALC at c3-c4, UPDATE at c5, CHECK at c6; done=1 at c7; iter_count=1; timeout=0.
REQ-034 Three iterations:
  - Stimulus: is_finished rises only in the third CHECK.
  - Response: done at c15; iter_count=3; load_a high at c2, c5, c9, c13 only.
REQ-035 Timeout, MAX_ITER=4:
  - Stimulus: is_finished held 0.
  - Response: done at c19; timeout=1; iter_count=4.
REQ-036 Tie at the limit, MAX_ITER=4:
  - Stimulus: is_finished=1 exactly at the fourth CHECK.
  - Response: done at c19; timeout=0.
REQ-037 Abort and start-while-busy:
  - Stimulus: abort at c8, with start held high throughout.
  - Response: IDLE at c9, no done, iter_count=1; a new run accepted at the c9 edge; INIT at c10.
REQ-038 Reset mid-run:
  - Stimulus: rst_n low between edges in CALC.
  - Response: all outputs 0 before the next edge; no done for 20 cycles without a new start.
